sevenseg_scan_ctrl: RTL



---
 rtl/sevenseg_scan_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Optional per-frame brightness (PWM within the drive window) when SEG_BRIGHTNESS_EN is defined.
module sevenseg_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 4096,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic [N_DIGITS-1:0]   disp_en_n,
  output logic [7:0]            seg_n,
  output logic                  frame_start
`ifdef SEG_BRIGHTNESS_EN
  ,
  input  logic [3:0]            brightness
`endif
);

  localparam int CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DRIVE_LEN = REFRESH_DIV - BLANK_CYCLES;

  localparam logic [CNT_W-1:0]    SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] DIGIT0    = N_DIGITS'(1);

  // Active-low CA..CG pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
  logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [N_DIGITS-1:0]   shadow_en_q, shadow_en_d;
  logic                  pending_q, pending_d;
  logic [4*N_DIGITS-1:0] active_digits_q, active_digits_d;
  logic [N_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [N_DIGITS-1:0]   active_en_q, active_en_d;
  logic [N_DIGITS-1:0]   disp_en_n_q, disp_en_n_d;
  logic [7:0]            seg_n_q, seg_n_d;
  logic                  frame_start_q, frame_start_d;
  logic                  slot_wrap;
  logic                  frame_wrap;
  logic                  lit;
`ifdef SEG_BRIGHTNESS_EN
  logic [3:0]            bright_q, bright_d;
  logic [31:0]           lit_len;
  logic [31:0]           drive_pos;
`endif

  always_comb begin
    slot_wrap  = (slot_cnt_q == SLOT_LAST);
    frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Shadow/active double buffer: the active copy only changes on the frame wrap,
  // and a load landing exactly on the wrap bypasses the shadow.
  always_comb begin
    shadow_digits_d = shadow_digits_q;
    shadow_dp_d     = shadow_dp_q;
    shadow_en_d     = shadow_en_q;
    pending_d       = pending_q;
    active_digits_d = active_digits_q;
    active_dp_d     = active_dp_q;
    active_en_d     = active_en_q;
    if (load && frame_wrap) begin
      shadow_digits_d = digits_in;
      shadow_dp_d     = dp_in;
      shadow_en_d     = digit_en;
      active_digits_d = digits_in;
      active_dp_d     = dp_in;
      active_en_d     = digit_en;
      pending_d       = 1'b0;
    end else if (frame_wrap && pending_q) begin
      active_digits_d = shadow_digits_q;
      active_dp_d     = shadow_dp_q;
      active_en_d     = shadow_en_q;
      pending_d       = 1'b0;
    end else if (load) begin
      shadow_digits_d = digits_in;
      shadow_dp_d     = dp_in;
      shadow_en_d     = digit_en;
      pending_d       = 1'b1;
    end
  end

`ifdef SEG_BRIGHTNESS_EN
  always_comb begin
    bright_d  = frame_wrap ? brightness : bright_q;
    lit_len   = (32'(DRIVE_LEN) * (32'(bright_q) + 32'd1)) >> 4;
    drive_pos = 32'(slot_cnt_q) - 32'(BLANK_CYCLES);
    lit       = (slot_cnt_q >= BLANK_END) && (drive_pos < lit_len);
  end
`else
  always_comb begin
    lit = (slot_cnt_q >= BLANK_END);
  end
`endif

  // Outputs are decoded from this cycle's counters and land one cycle later.
  always_comb begin
    disp_en_n_d   = '1;
    seg_n_d       = 8'hFF;
    frame_start_d = (slot_cnt_q == '0) && (idx_q == '0);
    if (lit && active_en_q[idx_q]) begin
      disp_en_n_d = ~(DIGIT0 << idx_q);
      seg_n_d     = {~active_dp_q[idx_q], hex_to_seg(active_digits_q[{idx_q, 2'b00} +: 4])};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_q      <= '0;
      idx_q           <= '0;
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      shadow_en_q     <= '0;
      pending_q       <= 1'b0;
      active_digits_q <= '0;
      active_dp_q     <= '0;
      active_en_q     <= '0;
      disp_en_n_q     <= '1;
      seg_n_q         <= 8'hFF;
      frame_start_q   <= 1'b0;
`ifdef SEG_BRIGHTNESS_EN
      bright_q        <= 4'hF;
`endif
    end else begin
      slot_cnt_q      <= slot_cnt_d;
      idx_q           <= idx_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      shadow_en_q     <= shadow_en_d;
      pending_q       <= pending_d;
      active_digits_q <= active_digits_d;
      active_dp_q     <= active_dp_d;
      active_en_q     <= active_en_d;
      disp_en_n_q     <= disp_en_n_d;
      seg_n_q         <= seg_n_d;
      frame_start_q   <= frame_start_d;
`ifdef SEG_BRIGHTNESS_EN
      bright_q        <= bright_d;
`endif
    end
  end

  assign disp_en_n   = disp_en_n_q;
  assign seg_n       = seg_n_q;
  assign frame_start = frame_start_q;

endmodule
